// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage data port master (req/addr_ok/data_ok) with store lane
//            replication and load extract/extend. Optional misalignment
//            trap: MEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic        mem_ex_sign,
  input  logic [1:0]  mem_seg,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_sign;
  logic        r_discard;
  logic [31:0] r_load_data;

  logic        w_misaligned;
  logic        w_start;
  logic        w_latch;
  logic        w_capture;
  logic        w_set_discard;
  logic        w_kill;
  logic        w_mem_stall;
  logic [1:0]  w_size;
  logic [31:0] w_wdata_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    if ((r_state == S_IDLE) && mem_en) begin
      w_misaligned = ((mem_seg == 2'b01) && mem_addr[0]) ||
                     (mem_seg[1] && (mem_addr[1:0] != 2'b00));
    end
  end
  assign adel      = w_misaligned & ~mem_write;
  assign ades      = w_misaligned &  mem_write;
  assign bad_vaddr = w_misaligned ? mem_addr : 32'd0;
`else
  assign w_misaligned = 1'b0;
  assign adel         = 1'b0;
  assign ades         = 1'b0;
  assign bad_vaddr    = 32'd0;
`endif

  assign w_start = mem_en & ~flush & ~w_misaligned;
  // A flush seen now or earlier in the transaction drops the result.
  assign w_kill  = r_discard | flush;

  // Size code 11 is treated as a word access.
  always_comb begin
    case (mem_seg)
      2'b00:   begin w_size = 2'd0; w_wdata_lane = {4{mem_wdata[7:0]}};  end
      2'b01:   begin w_size = 2'd1; w_wdata_lane = {2{mem_wdata[15:0]}}; end
      default: begin w_size = 2'd2; w_wdata_lane = mem_wdata;            end
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = data_rdata[7:0];
      2'b01:   w_byte = data_rdata[15:8];
      2'b10:   w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_size)
      2'd0:    w_ext = {{24{r_sign & w_byte[7]}}, w_byte};
      2'd1:    w_ext = {{16{r_sign & w_half[15]}}, w_half};
      default: w_ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_stall   = 1'b0;
    w_latch       = 1'b0;
    w_capture     = 1'b0;
    w_set_discard = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mem_stall = w_start;
        if (w_start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_mem_stall   = 1'b1;
        w_set_discard = flush;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            w_capture   = 1'b1;
            w_state_nxt = w_kill ? S_IDLE : S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_mem_stall   = 1'b1;
        w_set_discard = flush;
        if (data_data_ok) begin
          w_capture   = 1'b1;
          w_state_nxt = w_kill ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (flush || !pipe_stall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_sign      <= 1'b0;
      r_discard   <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      if (w_latch) begin
        r_wr    <= mem_write;
        r_size  <= w_size;
        r_addr  <= mem_addr;
        r_wdata <= w_wdata_lane;
        r_sign  <= mem_ex_sign;
      end
      if (w_state_nxt == S_IDLE) r_discard <= 1'b0;
      else if (w_set_discard)    r_discard <= 1'b1;
      if (w_capture && !w_kill)  r_load_data <= r_wr ? 32'd0 : w_ext;
    end
  end

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign mem_stall  = w_mem_stall;
  assign done       = (r_state == S_DONE);
  assign load_data  = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboarded directed bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_write, mem_ex_sign;
  logic [1:0]  mem_seg;
  logic [31:0] mem_addr, mem_wdata;
  logic        flush, pipe_stall;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        done, adel, ades;
  logic [31:0] bad_vaddr;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  logic prev_done = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_write(mem_write), .mem_ex_sign(mem_ex_sign),
    .mem_seg(mem_seg), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush), .pipe_stall(pipe_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .done(done),
    .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Request monitor: every accepted handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && data_req && data_addr_ok) begin
      acc_cnt++;
      if (req_q.size() == 0) begin
        chk("unexpected_request", 32'd1, 32'd0);
      end else begin
        req_t e;
        e = req_q.pop_front();
        chk("req_addr",  data_addr,  e.addr);
        chk("req_size",  {30'd0, data_size}, {30'd0, e.size});
        chk("req_wr",    {31'd0, data_wr},   {31'd0, e.wr});
        chk("req_wdata", data_wdata, e.wdata);
      end
    end
  end

  // Completion monitor: first cycle of each done pulse pops the expected result.
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      if (ld_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else                  chk("load_data", load_data, ld_q.pop_front());
    end
    prev_done = done;
  end

  // Assumes called at posedge+1 with the DUT in IDLE.
  task automatic do_acc(input string nm, input logic wr, input logic sgn,
                        input logic [1:0] seg, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_wd,
                        input logic [1:0] exp_sz, input logic [31:0] rdata,
                        input logic [31:0] exp_ld, input int a, input int d,
                        input int fl, input int ps, input int exp_stall);
    int stall_cnt;
    req_t e;
    stall_cnt = 0;
    e.addr = addr; e.size = exp_sz; e.wr = wr; e.wdata = exp_wd;
    req_q.push_back(e);
    if (fl <= 0) ld_q.push_back(exp_ld);
    mem_en = 1'b1; mem_write = wr; mem_ex_sign = sgn; mem_seg = seg;
    mem_addr = addr; mem_wdata = wdata;
    @(negedge clk);
    chk({nm, "_stall_start"}, {31'd0, mem_stall}, 32'd1);
    chk({nm, "_req_not_yet"}, {31'd0, data_req}, 32'd0);
    if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    for (int k = 0; k < a; k++) begin
      @(negedge clk);
      chk({nm, "_req_held"},   {31'd0, data_req}, 32'd1);
      chk({nm, "_addr_held"},  data_addr, addr);
      chk({nm, "_wdata_held"}, data_wdata, exp_wd);
      if (mem_stall) stall_cnt++;
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b1;
    if (d == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
    @(negedge clk);
    chk({nm, "_req_accept"}, {31'd0, data_req}, 32'd1);
    if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    for (int k = 1; k <= d; k++) begin
      if (k == d) begin data_data_ok = 1'b1; data_rdata = rdata; end
      if (k == fl) begin flush = 1'b1; mem_en = 1'b0; end
      @(negedge clk);
      chk({nm, "_no_done_wait"}, {31'd0, done}, 32'd0);
      if (mem_stall) stall_cnt++;
      @(posedge clk); #1;
      data_data_ok = 1'b0; flush = 1'b0; data_rdata = 32'hDEAD_0000;
    end
    if (fl > 0) begin
      @(negedge clk);
      chk({nm, "_flush_stall_drop"}, {31'd0, mem_stall}, 32'd0);
      chk({nm, "_flush_no_done"},    {31'd0, done}, 32'd0);
    end else begin
      pipe_stall = (ps > 0);
      for (int k = 0; k <= ps; k++) begin
        if (k == ps) begin pipe_stall = 1'b0; mem_en = 1'b0; end
        @(negedge clk);
        chk({nm, "_done_held"},   {31'd0, done}, 32'd1);
        chk({nm, "_done_nostall"}, {31'd0, mem_stall}, 32'd0);
        chk({nm, "_ld_stable"},   load_data, exp_ld);
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk({nm, "_back_idle"}, {31'd0, done}, 32'd0);
    end
    chk({nm, "_stall_cycles"}, stall_cnt, exp_stall);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst = 1'b1; mem_en = 1'b0; mem_write = 1'b0; mem_ex_sign = 1'b0;
    mem_seg = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0; flush = 1'b0;
    pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, data_req}, 32'd0);
    chk("rst_wr",    {31'd0, data_wr}, 32'd0);
    chk("rst_size",  {30'd0, data_size}, 32'd0);
    chk("rst_addr",  data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_ld",    load_data, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_exc",   {30'd0, adel, ades}, 32'd0);
    chk("rst_bva",   bad_vaddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Stray data_ok in IDLE must be ignored.
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_dataok_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    //     name   wr  sg seg    addr          wdata         exp_wd        sz    rdata         exp_ld        a d fl ps stall
    do_acc("lb",  0, 1, 2'b00, 32'h8000_0003, 32'h0,        32'h0,        2'd0, 32'h80FF_FF7F, 32'hFFFF_FF80, 0, 1, 0, 0, 3);
    do_acc("lhu", 0, 0, 2'b01, 32'h8000_0002, 32'h0,        32'h0,        2'd1, 32'hBEEF_1234, 32'h0000_BEEF, 0, 1, 0, 0, 3);
    do_acc("lh",  0, 1, 2'b01, 32'h8000_0002, 32'h0,        32'h0,        2'd1, 32'hBEEF_1234, 32'hFFFF_BEEF, 0, 1, 0, 0, 3);
    do_acc("lbu", 0, 0, 2'b00, 32'h8000_0001, 32'h0,        32'h0,        2'd0, 32'h1122_8344, 32'h0000_0083, 1, 2, 0, 0, 5);
    do_acc("sb",  1, 0, 2'b00, 32'h8000_0001, 32'h1234_56AB, 32'hABAB_ABAB, 2'd0, 32'hFFFF_FFFF, 32'h0,        4, 1, 0, 0, 7);
    do_acc("sh",  1, 0, 2'b01, 32'h8000_0002, 32'h0000_CAFE, 32'hCAFE_CAFE, 2'd1, 32'h0,        32'h0,        0, 1, 0, 0, 3);
    do_acc("lw0", 0, 0, 2'b10, 32'h8000_0004, 32'h0,        32'h0,        2'd2, 32'h0123_4567, 32'h0123_4567, 0, 0, 0, 0, 2);
    do_acc("seg3",0, 0, 2'b11, 32'h8000_0008, 32'h0,        32'h0,        2'd2, 32'h89AB_CDEF, 32'h89AB_CDEF, 0, 1, 0, 0, 3);
    do_acc("lwfl",0, 0, 2'b10, 32'h8000_0010, 32'h0,        32'h0,        2'd2, 32'h5555_AAAA, 32'h0,        0, 5, 2, 0, 7);
    acc0 = acc_cnt;
    do_acc("lwps",0, 0, 2'b10, 32'h8000_0020, 32'h0,        32'h0,        2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 0, 2, 3);
    chk("lwps_one_request", acc_cnt - acc0, 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
    mem_en = 1'b1; mem_write = 1'b1; mem_seg = 2'b10;
    mem_addr = 32'h8000_0006; mem_wdata = 32'h55AA_55AA;
    @(negedge clk);
    chk("sw_mis_ades",  {31'd0, ades}, 32'd1);
    chk("sw_mis_adel",  {31'd0, adel}, 32'd0);
    chk("sw_mis_bva",   bad_vaddr, 32'h8000_0006);
    chk("sw_mis_stall", {31'd0, mem_stall}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sw_mis_noreq", {31'd0, data_req}, 32'd0);
    end
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(posedge clk); #1;
`else
    do_acc("swmis",1, 0, 2'b10, 32'h8000_0006, 32'h55AA_55AA, 32'h55AA_55AA, 2'd2, 32'h0, 32'h0, 0, 1, 0, 0, 3);
    chk("swmis_exc", {30'd0, adel, ades}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ld_q_empty",  ld_q.size(),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Data-side memory access unit for the MEM stage of the pipelined MIPS core. It consumes the memory control bits produced by the main decoder (MemEn, MemWrite, MemExSign, MemSeg). It drives one transaction per instruction on the SRAM-like data port (req/addr_ok/data_ok), stalling the pipeline until the transaction completes. It replicates store data onto byte lanes, and extracts and extends load data before handing it to write-back.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  core clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  MEM-stage instruction accesses memory.
- mem_write  in  1  1 = store, 0 = load.
- mem_ex_sign  in  1  load result sign-extended (1) or zero-extended (0).
- mem_seg  in  2  access size: 00 byte, 01 halfword, 10 word; 11 treated as word.
- mem_addr  in  32  effective virtual address (ALU result).
- mem_wdata  in  32  rt value for stores.
- flush  in  1  exception/eret flush of MEM stage.
- pipe_stall  in  1  stage held by another stall source.
- data_req  out  1  request valid.
- data_wr  out  1  request is a write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  request address, unmodified.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  read data valid / write complete this cycle.
- data_rdata  in  32  read data.
- mem_stall  out  1  hold IF..MEM.
- load_data  out  32  extended load result, valid while done=1.
- done  out  1  access complete for current MEM instruction.
- adel, ades, bad_vaddr  out  1/1/32  misalignment exceptions (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DONE. start = mem_en & ~flush & ~misaligned (misaligned is forced 0 when the check is compiled out).
- IDLE: on start, latch wr, size, addr, wdata, sign → REQ. mem_stall = start (combinational).
- REQ: data_req=1 with latched fields; mem_stall=1. On data_addr_ok → WAIT; if data_data_ok is also high in the same cycle, capture and go to DONE.
- WAIT: mem_stall=1. On data_data_ok, capture the extracted load data → DONE.
- DONE: done=1, mem_stall=0, load_data held. When ~pipe_stall → IDLE. flush → IDLE.
- Flush in REQ: req stays high until addr_ok; then set discard and continue. Flush in WAIT: set discard. On data_ok with discard → IDLE, done never asserted. mem_stall stays 1 until data_ok, so the pipeline never issues over an outstanding transaction.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load extract: byte lane = addr[1:0] (00 → [7:0] … 11 → [31:24]); half lane = addr[1] (0 → [15:0], 1 → [31:16]); then sign- or zero-extend to 32. Stores leave load_data at 0.
- Reset: state IDLE, discard 0. All outputs 0: data_req, data_wr, data_size, data_addr, data_wdata, mem_stall, load_data, done, adel, ades, bad_vaddr. Reset mid-transaction abandons it; the interconnect shares rst.

## Timing
- Request fields are registered; data_req first rises the cycle after start.
- Minimum load/store latency, with addr_ok in the first REQ cycle and data_ok one cycle later: 3 stall cycles. Cycle 0 is IDLE with stall=1, cycle 1 REQ, cycle 2 WAIT, cycle 3 DONE with stall=0.
- data_req, data_wr, data_size, data_addr and data_wdata are stable from REQ entry until addr_ok.
- data_data_ok outside WAIT/REQ is ignored.
- done and load_data are registered and stable throughout DONE.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - misaligned = (half & addr[0]) | (word & addr[1:0]≠0) while in IDLE with mem_en.
  - adel = misaligned & ~mem_write; ades = misaligned & mem_write; bad_vaddr = mem_addr. All three are combinational and 0 outside that condition.
  - No request is issued and mem_stall stays 0.
- MEM_ALIGN_CHECK_EN undefined: adel, ades and bad_vaddr are tied to 0, and every access is issued with the address unmodified.

## Test plan
- LB at 0x8000_0003, rdata 0x80FF_FF7F, addr_ok immediate, data_ok +1 → data_addr 0x8000_0003, data_size 0; load_data 0xFFFF_FF80 after 3 stall cycles.
- LHU at 0x8000_0002, rdata 0xBEEF_1234 → load_data 0x0000_BEEF. Same access with LH → 0xFFFF_BEEF.
- SB wdata 0x1234_56AB at 0x8000_0001, addr_ok delayed 4 cycles → req, addr and data_wdata 0xABAB_ABAB held for all 5 REQ cycles; data_wr=1.
- LW, flush asserted one cycle into WAIT, data_ok 3 cycles later → done stays 0, FSM returns to IDLE, mem_stall drops the cycle after data_ok.
- LW in DONE with pipe_stall high 2 cycles → exactly one request issued; done held 3 cycles.
- MEM_ALIGN_CHECK_EN: SW at 0x8000_0006 → ades=1, bad_vaddr 0x8000_0006, data_req never asserted. Without the macro → request issued at 0x8000_0006.
